rv32_icache: RTL and testbench

RV32_ICACHE -- requirements
Module: rv32_icache

---
 rtl/rv32_icache_pkg.sv | 32 +++
 rtl/rv32_icache_store.sv | 60 ++++++
 rtl/rv32_icache.sv | 142 ++++++++++++++
 tb/tb_rv32_icache.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_icache_pkg.sv
// Shared RV32 definitions: base opcodes, the canonical NOP word and the
// instruction-cache controller state encoding.
package rv32_icache_pkg;

   // RV32I major opcodes (instruction bits [6:0])
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   // addi x0, x0, 0 -- handed to fetch whenever no real instruction is available
   localparam logic [31:0] RV32_NOP = 32'h00000013;

   // Cache controller states: looking up (IDLE) or waiting on a line fill (REQ)
   typedef enum logic [0:0] {
      ICACHE_IDLE = 1'b0,
      ICACHE_REQ  = 1'b1
   } icache_state_e;

   // Rebuild a byte address from a 30-bit word address
   function automatic logic [31:0] byte_of_word(input logic [29:0] word_addr);
      return {word_addr, 2'b00};
   endfunction

endpackage

// File: rtl/rv32_icache_store.sv
// Line storage for the direct-mapped instruction cache: per-line valid bits
// (reset and bulk-clearable), plus tag and data arrays with an asynchronous
// read port and a single synchronous write port.
module rv32_icache_store #(
   parameter int LINES = 16,
   parameter int IDX_W = 4,
   parameter int TAG_W = 26
) (
   input  logic             clk,
   input  logic             reset_,
   // lookup port
   input  logic [IDX_W-1:0] rd_index_i,
   output logic             rd_valid_o,
   output logic [TAG_W-1:0] rd_tag_o,
   output logic [31:0]      rd_data_o,
   // fill port
   input  logic             wr_en_i,
   input  logic [IDX_W-1:0] wr_index_i,
   input  logic [TAG_W-1:0] wr_tag_i,
   input  logic [31:0]      wr_data_i,
   // invalidate every line at the next edge
   input  logic             clear_i
);

   logic [LINES-1:0] valid_q;
   logic [TAG_W-1:0] tag_mem  [LINES];
   logic [31:0]      data_mem [LINES];

   // One valid flop per line; a clear always wins over a simultaneous fill
   generate
      for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
         // Per-line valid bit: reset/clear drop it, a fill to this index sets it
         always_ff @(posedge clk or negedge reset_) begin
            if (!reset_) begin
               valid_q[gi] <= 1'b0;
            end else if (clear_i) begin
               valid_q[gi] <= 1'b0;
            end else if (wr_en_i && (wr_index_i == IDX_W'(gi))) begin
               valid_q[gi] <= 1'b1;
            end
         end
      end
   endgenerate

   // Tag and data arrays carry no reset; valid_q alone decides whether they mean anything
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         tag_mem[wr_index_i]  <= wr_tag_i;
         data_mem[wr_index_i] <= wr_data_i;
      end
   end

   // Zero-latency lookup so a hit is answered in the request cycle
   always_comb begin
      rd_valid_o = valid_q[rd_index_i];
      rd_tag_o   = tag_mem[rd_index_i];
      rd_data_o  = data_mem[rd_index_i];
   end

endmodule

// File: rtl/rv32_icache.sv
// Direct-mapped, one-word-per-line instruction cache sitting between the
// fetch stage and a handshaked backing memory. Hits are answered
// combinationally; a miss issues a single word read and stalls fetch until
// the line is filled. A flush (fence.i) invalidates everything and, if it
// lands during a fill, causes that fill's data to be dropped.
// LINES must be a power of two, at least 2.
import rv32_icache_pkg::*;

module rv32_icache #(
   parameter int LINES = 16
) (
   input  logic        clk,
   input  logic        reset_,
   input  logic        instr_read_in,
   input  logic [31:0] instr_address_in,
   output logic [31:0] instr_read_value_out,
   output logic        instr_ready_out,
   input  logic        flush_in,
   output logic        mem_read_out,
   output logic [31:0] mem_address_out,
   input  logic        mem_ready_in,
   input  logic [31:0] mem_read_value_in
);

   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = 30 - IDX_W;

   icache_state_e    state_q, state_d;
   logic [29:0]      miss_word_q, miss_word_d;
   logic             discard_q, discard_d;

   logic [IDX_W-1:0] lookup_index;
   logic [TAG_W-1:0] lookup_tag;
   logic             line_valid;
   logic [TAG_W-1:0] line_tag;
   logic [31:0]      line_data;

   logic             in_idle;
   logic             tag_hit;
   logic             hit;
   logic             miss;
   logic             fill_done;
   logic             fill_write;
   logic [IDX_W-1:0] fill_index;
   logic [TAG_W-1:0] fill_tag;
   logic             addr_unused;

   // Byte offset within the word plays no part in lookup
   assign addr_unused  = ^instr_address_in[1:0];
   assign lookup_index = instr_address_in[IDX_W+1:2];
   assign lookup_tag   = instr_address_in[31:IDX_W+2];

   // The latched miss word address also provides the fill index and tag
   assign fill_index = miss_word_q[IDX_W-1:0];
   assign fill_tag   = miss_word_q[29:IDX_W];

   assign in_idle   = (state_q == ICACHE_IDLE);
   assign tag_hit   = line_valid && (line_tag == lookup_tag);
   // A flush cycle reports neither hit nor miss
   assign hit       = instr_read_in && in_idle && !flush_in && tag_hit;
   assign miss      = instr_read_in && in_idle && !flush_in && !tag_hit;
   assign fill_done = (state_q == ICACHE_REQ) && mem_ready_in;
   // Data from a fill overlapped by a flush (earlier or this cycle) is stale
   assign fill_write = fill_done && !discard_q && !flush_in;

   rv32_icache_store #(
      .LINES (LINES),
      .IDX_W (IDX_W),
      .TAG_W (TAG_W)
   ) u_store (
      .clk        (clk),
      .reset_     (reset_),
      .rd_index_i (lookup_index),
      .rd_valid_o (line_valid),
      .rd_tag_o   (line_tag),
      .rd_data_o  (line_data),
      .wr_en_i    (fill_write),
      .wr_index_i (fill_index),
      .wr_tag_i   (fill_tag),
      .wr_data_i  (mem_read_value_in),
      .clear_i    (flush_in)
   );

   // State register; reset forces IDLE at once, abandoning any fill in flight
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state_q <= ICACHE_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: start a fill on a miss, return to lookup when memory answers
   always_comb begin
      state_d = state_q;
      case (state_q)
         ICACHE_IDLE: if (miss)         state_d = ICACHE_REQ;
         ICACHE_REQ:  if (mem_ready_in) state_d = ICACHE_IDLE;
         default:                       state_d = ICACHE_IDLE;
      endcase
   end

   // Miss address and discard flag: what to fetch, and whether to keep it
   always_comb begin
      miss_word_d = miss_word_q;
      discard_d   = discard_q;
      if (miss) begin
         miss_word_d = instr_address_in[31:2];
      end
      if (in_idle) begin
         discard_d = 1'b0;
      end else if (mem_ready_in) begin
         discard_d = 1'b0;
      end else if (flush_in) begin
         discard_d = 1'b1;
      end
   end

   // Registers for the fill bookkeeping
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         miss_word_q <= '0;
         discard_q   <= 1'b0;
      end else begin
         miss_word_q <= miss_word_d;
         discard_q   <= discard_d;
      end
   end

   // Outputs: an idle fetch port is always "ready" with a NOP; the memory
   // request is held stable for the whole REQ state
   always_comb begin
      instr_ready_out      = !instr_read_in || hit;
      instr_read_value_out = hit ? line_data : RV32_NOP;
      mem_read_out         = (state_q == ICACHE_REQ);
      mem_address_out      = '0;
      if (state_q == ICACHE_REQ) begin
         mem_address_out = byte_of_word(miss_word_q);
      end
   end

endmodule

// File: tb/tb_rv32_icache.sv
// Self-checking bench for rv32_icache: directed vector table, hand-written
// flush/reset sequences, then randomized traffic against a residency model.
module tb_rv32_icache;

   localparam int          LINES = 16;
   localparam logic [31:0] NOP   = 32'h00000013;
   localparam logic [31:0] JUNK  = 32'hBAD0BAD0;

   logic        clk;
   logic        reset_;
   logic        instr_read_in;
   logic [31:0] instr_address_in;
   logic [31:0] instr_read_value_out;
   logic        instr_ready_out;
   logic        flush_in;
   logic        mem_read_out;
   logic [31:0] mem_address_out;
   logic        mem_ready_in;
   logic [31:0] mem_read_value_in;

   int checks = 0;
   int errors = 0;

   rv32_icache #(.LINES(LINES)) dut (
      .clk                  (clk),
      .reset_               (reset_),
      .instr_read_in        (instr_read_in),
      .instr_address_in     (instr_address_in),
      .instr_read_value_out (instr_read_value_out),
      .instr_ready_out      (instr_ready_out),
      .flush_in             (flush_in),
      .mem_read_out         (mem_read_out),
      .mem_address_out      (mem_address_out),
      .mem_ready_in         (mem_ready_in),
      .mem_read_value_in    (mem_read_value_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rd;
      logic [31:0] addr;
      logic        flush;
      logic        mrdy;
      logic [31:0] mdata;
      logic        exp_rdy;
      logic [31:0] exp_val;
      logic        exp_mrd;
      logic [31:0] exp_maddr;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic rd, logic [31:0] addr, logic flush, logic mrdy,
                               logic [31:0] mdata, logic exp_rdy, logic [31:0] exp_val,
                               logic exp_mrd, logic [31:0] exp_maddr);
      vec_t v;
      v.rd = rd; v.addr = addr; v.flush = flush; v.mrdy = mrdy; v.mdata = mdata;
      v.exp_rdy = exp_rdy; v.exp_val = exp_val; v.exp_mrd = exp_mrd; v.exp_maddr = exp_maddr;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Drive one cycle's inputs, check outputs mid-cycle, advance past the edge
   task automatic run(input vec_t v, input string name);
      instr_read_in     = v.rd;
      instr_address_in  = v.addr;
      flush_in          = v.flush;
      mem_ready_in      = v.mrdy;
      mem_read_value_in = v.mdata;
      #3;
      $display("%s rd=%0d addr=%h flush=%0d mrdy=%0d -> rdy=%0d val=%h mrd=%0d maddr=%h",
               name, v.rd, v.addr, v.flush, v.mrdy, instr_ready_out, instr_read_value_out,
               mem_read_out, mem_address_out);
      chk({name, ".ready"}, {31'd0, instr_ready_out}, {31'd0, v.exp_rdy});
      chk({name, ".value"}, instr_read_value_out, v.exp_val);
      chk({name, ".mem_read"}, {31'd0, mem_read_out}, {31'd0, v.exp_mrd});
      chk({name, ".mem_addr"}, mem_address_out, v.exp_maddr);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_            = 1'b0;
      instr_read_in     = 1'b0;
      instr_address_in  = '0;
      flush_in          = 1'b0;
      mem_ready_in      = 1'b0;
      mem_read_value_in = '0;
      repeat (2) @(posedge clk);
      #1;
      reset_ = 1'b1;
   endtask

   // Backing-memory contents used by the random phase
   function automatic logic [31:0] memdata(input logic [29:0] w);
      logic [31:0] x;
      x = {w, 2'b00};
      return (x * 32'h9E3779B1) ^ 32'h5A5A1234;
   endfunction

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      a = ($urandom_range(0, 2) << 6) | ($urandom_range(0, LINES - 1) << 2)
          | $urandom_range(0, 3);
      a[31] = $urandom_range(0, 1) == 1;
      return a;
   endfunction

   // Residency model: which word address each line holds, if any
   bit          cached_v [LINES];
   logic [29:0] cached_w [LINES];

   initial begin
      do_reset();

      // Reset-state outputs while reset_ is held
      reset_ = 1'b0;
      instr_read_in = 1'b0;
      #2;
      chk("reset.ready_idle", {31'd0, instr_ready_out}, 32'd1);
      chk("reset.value", instr_read_value_out, NOP);
      chk("reset.mem_read", {31'd0, mem_read_out}, 32'd0);
      chk("reset.mem_addr", mem_address_out, 32'd0);
      instr_read_in = 1'b1;
      instr_address_in = 32'h100;
      #1;
      chk("reset.ready_read", {31'd0, instr_ready_out}, 32'd0);
      do_reset();

      // ---------------- directed vector table ----------------
      vecs.push_back(mk(0, 32'h000, 0, 0, JUNK, 1, NOP, 0, 32'h0));          // idle port
      vecs.push_back(mk(1, 32'h100, 0, 0, JUNK, 0, NOP, 0, 32'h0));          // cold miss
      vecs.push_back(mk(1, 32'h100, 0, 0, JUNK, 0, NOP, 1, 32'h100));        // wait 1
      vecs.push_back(mk(1, 32'h100, 0, 0, JUNK, 0, NOP, 1, 32'h100));        // wait 2
      vecs.push_back(mk(1, 32'h100, 0, 0, JUNK, 0, NOP, 1, 32'h100));        // wait 3
      vecs.push_back(mk(1, 32'h100, 0, 1, 32'hDEADBEEF, 0, NOP, 1, 32'h100));
      vecs.push_back(mk(1, 32'h100, 0, 0, JUNK, 1, 32'hDEADBEEF, 0, 32'h0)); // hit
      vecs.push_back(mk(1, 32'h102, 0, 0, JUNK, 1, 32'hDEADBEEF, 0, 32'h0)); // byte bits ignored
      vecs.push_back(mk(1, 32'h140, 0, 0, JUNK, 0, NOP, 0, 32'h0));          // conflict miss
      vecs.push_back(mk(1, 32'h140, 0, 1, 32'h11111111, 0, NOP, 1, 32'h140));
      vecs.push_back(mk(1, 32'h140, 0, 0, JUNK, 1, 32'h11111111, 0, 32'h0));
      vecs.push_back(mk(1, 32'h100, 0, 0, JUNK, 0, NOP, 0, 32'h0));          // evicted
      vecs.push_back(mk(1, 32'h100, 0, 1, 32'hDEADBEEF, 0, NOP, 1, 32'h100));
      vecs.push_back(mk(1, 32'h100, 0, 0, JUNK, 1, 32'hDEADBEEF, 0, 32'h0));
      vecs.push_back(mk(0, 32'h100, 0, 0, JUNK, 1, NOP, 0, 32'h0));
      vecs.push_back(mk(1, 32'h300, 0, 0, JUNK, 0, NOP, 0, 32'h0));          // miss 0x300
      vecs.push_back(mk(1, 32'h400, 0, 0, JUNK, 0, NOP, 1, 32'h300));        // addr changes
      vecs.push_back(mk(1, 32'h400, 0, 1, 32'h33333333, 0, NOP, 1, 32'h300));
      vecs.push_back(mk(1, 32'h400, 0, 0, JUNK, 0, NOP, 0, 32'h0));          // re-evaluated, misses
      vecs.push_back(mk(1, 32'h400, 0, 1, 32'h44444444, 0, NOP, 1, 32'h400));
      vecs.push_back(mk(1, 32'h300, 0, 0, JUNK, 0, NOP, 0, 32'h0));          // overwritten
      vecs.push_back(mk(1, 32'h300, 0, 1, 32'h33333333, 0, NOP, 1, 32'h300));
      vecs.push_back(mk(1, 32'h300, 0, 0, JUNK, 1, 32'h33333333, 0, 32'h0));
      vecs.push_back(mk(1, 32'h300, 1, 0, JUNK, 0, NOP, 0, 32'h0));          // flush in IDLE
      vecs.push_back(mk(1, 32'h300, 0, 0, JUNK, 0, NOP, 0, 32'h0));          // now misses
      vecs.push_back(mk(1, 32'h300, 0, 1, 32'h33333333, 0, NOP, 1, 32'h300));
      vecs.push_back(mk(1, 32'h300, 0, 0, JUNK, 1, 32'h33333333, 0, 32'h0));
      vecs.push_back(mk(0, 32'h300, 1, 0, JUNK, 1, NOP, 0, 32'h0));          // flush, port idle
      vecs.push_back(mk(1, 32'h300, 0, 0, JUNK, 0, NOP, 0, 32'h0));          // flushed line misses
      vecs.push_back(mk(1, 32'h300, 0, 1, 32'h33333333, 0, NOP, 1, 32'h300));

      foreach (vecs[i]) run(vecs[i], $sformatf("vec%0d", i));

      // ---------------- flush while a fill is outstanding ----------------
      do_reset();
      run(mk(1, 32'h200, 0, 0, JUNK, 0, NOP, 0, 32'h0), "fr.miss");
      run(mk(1, 32'h200, 1, 0, JUNK, 0, NOP, 1, 32'h200), "fr.flush");
      run(mk(1, 32'h200, 0, 0, JUNK, 0, NOP, 1, 32'h200), "fr.wait");
      run(mk(1, 32'h200, 0, 1, 32'h22222222, 0, NOP, 1, 32'h200), "fr.done");
      run(mk(1, 32'h200, 0, 0, JUNK, 0, NOP, 0, 32'h0), "fr.remiss");
      run(mk(1, 32'h200, 0, 1, 32'h22222222, 0, NOP, 1, 32'h200), "fr.refill");
      run(mk(1, 32'h200, 0, 0, JUNK, 1, 32'h22222222, 0, 32'h0), "fr.hit");
      // flush in the very cycle memory answers: data still dropped
      run(mk(1, 32'h208, 0, 0, JUNK, 0, NOP, 0, 32'h0), "fr2.miss");
      run(mk(1, 32'h208, 1, 1, 32'h2222AAAA, 0, NOP, 1, 32'h208), "fr2.flushdone");
      run(mk(1, 32'h208, 0, 0, JUNK, 0, NOP, 0, 32'h0), "fr2.remiss");
      run(mk(1, 32'h208, 0, 1, 32'h2222AAAA, 0, NOP, 1, 32'h208), "fr2.refill");

      // ---------------- reset in the middle of a fill ----------------
      do_reset();
      run(mk(1, 32'h100, 0, 0, JUNK, 0, NOP, 0, 32'h0), "rr.miss");
      run(mk(1, 32'h100, 0, 1, 32'hDEADBEEF, 0, NOP, 1, 32'h100), "rr.fill");
      run(mk(1, 32'h100, 0, 0, JUNK, 1, 32'hDEADBEEF, 0, 32'h0), "rr.hit");
      run(mk(1, 32'h104, 0, 0, JUNK, 0, NOP, 0, 32'h0), "rr.miss104");
      instr_read_in = 1'b1;
      instr_address_in = 32'h104;
      mem_ready_in = 1'b0;
      #2;
      chk("rr.inreq_mem_read", {31'd0, mem_read_out}, 32'd1);
      reset_ = 1'b0;
      #1;
      $display("rr.reset mrd=%0d maddr=%h rdy=%0d", mem_read_out, mem_address_out, instr_ready_out);
      chk("rr.reset_mem_read", {31'd0, mem_read_out}, 32'd0);
      chk("rr.reset_mem_addr", mem_address_out, 32'd0);
      chk("rr.reset_ready", {31'd0, instr_ready_out}, 32'd0);
      chk("rr.reset_value", instr_read_value_out, NOP);
      mem_ready_in = 1'b1;
      mem_read_value_in = 32'h0BADF00D;
      @(posedge clk);
      #1;
      reset_ = 1'b1;
      run(mk(1, 32'h100, 0, 0, JUNK, 0, NOP, 0, 32'h0), "rr.after_100");
      run(mk(1, 32'h100, 0, 1, 32'hDEADBEEF, 0, NOP, 1, 32'h100), "rr.refill");
      run(mk(1, 32'h104, 0, 0, JUNK, 0, NOP, 0, 32'h0), "rr.after_104");
      run(mk(1, 32'h104, 0, 1, 32'h10410410, 0, NOP, 1, 32'h104), "rr.fill104");
      run(mk(1, 32'h104, 0, 0, JUNK, 1, 32'h10410410, 0, 32'h0), "rr.hit104");

      // ---------------- randomized traffic ----------------
      do_reset();
      begin
         bit          in_req;
         bit          discard;
         logic [29:0] req_w;
         logic [31:0] cur_addr;
         for (int i = 0; i < LINES; i++) begin
            cached_v[i] = 1'b0;
            cached_w[i] = '0;
         end
         in_req   = 1'b0;
         discard  = 1'b0;
         req_w    = '0;
         cur_addr = rand_addr();
         for (int c = 0; c < 3000; c++) begin
            bit          rd, fl, mr, exp_hit, exp_rdy, exp_mrd;
            logic [29:0] w;
            logic [31:0] exp_val, exp_ma;
            int          idx;
            if ($urandom_range(0, 3) == 0) cur_addr = rand_addr();
            rd  = ($urandom_range(0, 7) != 0);
            fl  = ($urandom_range(0, 39) == 0);
            mr  = ($urandom_range(0, 2) == 0);
            w   = cur_addr[31:2];
            idx = int'(w) % LINES;
            if (!in_req) begin
               exp_hit = rd && !fl && cached_v[idx] && (cached_w[idx] == w);
               exp_rdy = !rd || exp_hit;
               exp_val = exp_hit ? memdata(w) : NOP;
               exp_mrd = 1'b0;
               exp_ma  = 32'h0;
            end else begin
               exp_hit = 1'b0;
               exp_rdy = !rd;
               exp_val = NOP;
               exp_mrd = 1'b1;
               exp_ma  = {req_w, 2'b00};
            end
            instr_read_in     = rd;
            instr_address_in  = cur_addr;
            flush_in          = fl;
            mem_ready_in      = mr;
            mem_read_value_in = (in_req && mr) ? memdata(req_w) : $urandom();
            #3;
            chk("rnd.ready", {31'd0, instr_ready_out}, {31'd0, exp_rdy});
            chk("rnd.value", instr_read_value_out, exp_val);
            chk("rnd.mem_read", {31'd0, mem_read_out}, {31'd0, exp_mrd});
            chk("rnd.mem_addr", mem_address_out, exp_ma);
            if (!in_req) begin
               if (fl) begin
                  for (int i = 0; i < LINES; i++) cached_v[i] = 1'b0;
               end else if (rd && !exp_hit) begin
                  in_req = 1'b1;
                  req_w  = w;
               end
            end else begin
               if (fl) begin
                  for (int i = 0; i < LINES; i++) cached_v[i] = 1'b0;
                  discard = 1'b1;
               end
               if (mr) begin
                  $display("rnd.fill cycle=%0d addr=%h kept=%0d", c, {req_w, 2'b00}, !discard);
                  if (!discard) begin
                     cached_v[int'(req_w) % LINES] = 1'b1;
                     cached_w[int'(req_w) % LINES] = req_w;
                  end
                  in_req  = 1'b0;
                  discard = 1'b0;
               end
            end
            @(posedge clk);
            #1;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
